vga_sync_porch: RTL and testbench
=================================

Name: vga_sync_porch

Overview:
- Downstream stage of the Pong game core.
- Takes the core's active-region sync signals (high during active video) and its 4-bit RGB video, and regenerates standard VGA timing.
- Produces active-low HSync/VSync pulses placed after the front porch and before the back porch, and blanks video outside the active area.
- Its outputs drive the board VGA pins directly.

Parameters:
- TOTAL_COLS, 800, pixels per line including blanking
- TOTAL_ROWS, 525, lines per frame including blanking
- ACTIVE_COLS, 640, visible pixels per line
- ACTIVE_ROWS, 480, visible lines per frame
- FRONT_PORCH_H, 18, columns between end of active video and HSync assertion
- BACK_PORCH_H, 50, columns between HSync deassertion and end of line
- FRONT_PORCH_V, 10, rows between end of active video and VSync assertion
- BACK_PORCH_V, 33, rows between VSync deassertion and end of frame
- VIDEO_DELAY, 2, cycles by which input video lags input sync (0..7)

Ports:
- i_Clk  in  1  pixel clock
- i_Rst_L  in  1  asynchronous active-low reset
- i_HSync  in  1  high during active columns
- i_VSync  in  1  high during active rows
- i_Red_Video  in  4  red, valid VIDEO_DELAY cycles after the matching sync sample
- i_Grn_Video  in  4  green, same timing as red
- i_Blu_Video  in  4  blue, same timing as red
- o_HSync  out  1  active-low horizontal sync with porches
- o_VSync  out  1  active-low vertical sync with porches
- o_Red_Video  out  4  blanked red
- o_Grn_Video  out  4  blanked green
- o_Blu_Video  out  4  blanked blue
- o_Locked  out  1  high once the first frame start has been seen
- o_Resync  out  1  one-cycle pulse when a frame start arrives at an unexpected position

Behaviour:
- Reset (async assert, sync release), all registers clear:
  - o_HSync=1, o_VSync=1, all video outputs 0, o_Locked=0, o_Resync=0.
  - Column/row counters and the video delay line are cleared to 0.
- Frame start: sample where i_VSync=1 and the previous sample of i_VSync=0. That input sample is pixel (col 0, row 0).
- Counters:
  - The column advances by 1 per sample and wraps at TOTAL_COLS-1 to 0.
  - On wrap, the row advances and wraps at TOTAL_ROWS-1 to 0.
  - Counter width is clog2 of the respective total.
  - A frame start always forces the sample to (0,0).
- Lock behaviour:
  - The first frame start after reset sets o_Locked=1; it is then held until reset.
  - A frame start while locked, when the free-running counters would not have yielded (0,0), pulses o_Resync for one cycle, aligned with output of that sample. Counters still reload.
  - While unlocked: o_HSync=o_VSync=1 and video=0 regardless of inputs.
- Sync generation, derived from the counters of each sample:
  - HSync low iff ACTIVE_COLS+FRONT_PORCH_H <= col <= TOTAL_COLS-BACK_PORCH_H-1.
  - VSync low iff ACTIVE_ROWS+FRONT_PORCH_V <= row <= TOTAL_ROWS-BACK_PORCH_V-1.
  - Otherwise high.
- Video path:
  - Input video is realigned to its sync sample through a VIDEO_DELAY-deep shift register; sync-derived coordinates are delayed to match.
  - A pixel passes unchanged iff col<ACTIVE_COLS and row<ACTIVE_ROWS; otherwise it is driven 0.
- Latency:
  - Every output for sample t is registered and appears at cycle t+2+VIDEO_DELAY: 1 cycle edge detect/count, VIDEO_DELAY alignment, 1 output register.
  - All outputs share this latency exactly.
- No i_HSync dependence beyond checking:
  - If i_HSync is high at col>=ACTIVE_COLS, the sample is still blanked; no error is raised.
- Reset mid-frame: outputs return to their reset values immediately; lock is reacquired on the next frame start.

Decomposition:
- Shared package vga_timing_pkg holds the default 640x480 timing constants (totals, active sizes, porches), shared with Pong and Sync_To_Count instantiation sites.
- One natural sub-module: vga_pixel_counter. It does frame-start edge detect, col/row counters, and unexpected-position detect, and outputs col, row, frame_start and resync.
- Delay line and blanking stay in the top.

Test Plan:
- Small config: TOTAL 10x6, ACTIVE 6x4, FP_H=1, BP_H=1, FP_V=0, BP_V=1, VIDEO_DELAY=2.
- Scenario 1, reset: hold i_Rst_L=0 with random inputs -> o_HSync=1, o_VSync=1, video=0, o_Locked=0. Release with no frame start for 100 cycles -> outputs unchanged.
- Scenario 2, first frame: drive a well-formed frame -> o_Locked rises 4 cycles after the first i_VSync rise. o_HSync low exactly at cols 7..8 of every line; o_VSync low for all of row 4 only.
- Scenario 3, blanking: input video constant 4'hF on all samples -> output 4'hF only at col 0..5 and row 0..3, 0 elsewhere, 24 lit pixels per frame.
- Scenario 4, alignment: video = col index of the sample VIDEO_DELAY cycles earlier -> output at col c equals c for c<6, exactly 4 cycles after the sync sample.
- Scenario 5, resync: shorten one frame by 3 samples -> o_Resync single pulse. Following frame timing is identical to scenario 2 with no further pulses.
- Scenario 6, mid-frame reset: assert i_Rst_L low at row 2 col 3 -> outputs reset asynchronously. After release, o_Locked stays 0 until the next frame start.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 VGA timing constants and shared types for the video
// output chain (Pong core, Sync_To_Count, vga_sync_porch).
package vga_timing_pkg;

  localparam int unsigned VGA_TOTAL_COLS    = 800;
  localparam int unsigned VGA_TOTAL_ROWS    = 525;
  localparam int unsigned VGA_ACTIVE_COLS   = 640;
  localparam int unsigned VGA_ACTIVE_ROWS   = 480;
  localparam int unsigned VGA_FRONT_PORCH_H = 18;
  localparam int unsigned VGA_BACK_PORCH_H  = 50;
  localparam int unsigned VGA_FRONT_PORCH_V = 10;
  localparam int unsigned VGA_BACK_PORCH_V  = 33;
  localparam int unsigned VGA_VIDEO_DELAY   = 2;

  // Lock tracking: searching for the first frame start, then held until reset.
  typedef enum logic {
    LOCK_SEARCH = 1'b0,
    LOCK_HELD   = 1'b1
  } lock_state_t;

  // Per-sample decisions carried alongside the video alignment delay.
  typedef struct packed {
    logic locked;
    logic resync;
    logic hs_low;
    logic vs_low;
    logic active;
  } sync_tag_t;

  // Counter width for a counter spanning 0..total-1 (never below 1 bit).
  function automatic int unsigned ctr_width(input int unsigned total);
    return (total <= 1) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/vga_pixel_counter.sv
// Frame-start edge detect and free-running column/row raster counters.
// Outputs are registered and describe the input sample of the previous cycle.
module vga_pixel_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL_COLS = VGA_TOTAL_COLS,
  parameter int unsigned TOTAL_ROWS = VGA_TOTAL_ROWS,
  localparam int unsigned COL_W = ctr_width(TOTAL_COLS),
  localparam int unsigned ROW_W = ctr_width(TOTAL_ROWS)
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_VSync,
  output logic [COL_W-1:0] o_Col,
  output logic [ROW_W-1:0] o_Row,
  output logic             o_Frame_Start,
  output logic             o_Resync
);

  logic             r_VSync_Prev;
  logic [COL_W-1:0] r_Col;
  logic [ROW_W-1:0] r_Row;
  logic             r_Frame_Start;
  logic             r_Resync;

  logic             w_Frame_Start;
  logic             w_Col_Wrap;
  logic             w_Row_Wrap;
  logic             w_Misplaced;
  logic [COL_W-1:0] w_Next_Col;
  logic [ROW_W-1:0] w_Next_Row;

  // Where the free-running raster would place this sample, and whether a
  // frame start arrives anywhere other than (0,0).
  always_comb begin
    w_Frame_Start = i_VSync & ~r_VSync_Prev;
    w_Col_Wrap    = (r_Col == COL_W'(TOTAL_COLS - 1));
    w_Row_Wrap    = (r_Row == ROW_W'(TOTAL_ROWS - 1));
    w_Next_Col    = w_Col_Wrap ? '0 : r_Col + COL_W'(1);
    w_Next_Row    = r_Row;
    if (w_Col_Wrap) begin
      w_Next_Row = w_Row_Wrap ? '0 : r_Row + ROW_W'(1);
    end
    w_Misplaced   = w_Frame_Start && ((w_Next_Col != '0) || (w_Next_Row != '0));
  end

  // Raster counters; a frame start always reloads to (0,0).
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_VSync_Prev  <= 1'b0;
      r_Col         <= '0;
      r_Row         <= '0;
      r_Frame_Start <= 1'b0;
      r_Resync      <= 1'b0;
    end else begin
      r_VSync_Prev  <= i_VSync;
      r_Col         <= w_Frame_Start ? '0 : w_Next_Col;
      r_Row         <= w_Frame_Start ? '0 : w_Next_Row;
      r_Frame_Start <= w_Frame_Start;
      r_Resync      <= w_Misplaced;
    end
  end

  assign o_Col         = r_Col;
  assign o_Row         = r_Row;
  assign o_Frame_Start = r_Frame_Start;
  assign o_Resync      = r_Resync;

endmodule

// File: rtl/vga_sync_porch.sv
// Regenerates VGA HSync/VSync with porches from the Pong core's active-region
// syncs, realigns its delayed video and blanks outside the active area.
module vga_sync_porch
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL_COLS    = VGA_TOTAL_COLS,
  parameter int unsigned TOTAL_ROWS    = VGA_TOTAL_ROWS,
  parameter int unsigned ACTIVE_COLS   = VGA_ACTIVE_COLS,
  parameter int unsigned ACTIVE_ROWS   = VGA_ACTIVE_ROWS,
  parameter int unsigned FRONT_PORCH_H = VGA_FRONT_PORCH_H,
  parameter int unsigned BACK_PORCH_H  = VGA_BACK_PORCH_H,
  parameter int unsigned FRONT_PORCH_V = VGA_FRONT_PORCH_V,
  parameter int unsigned BACK_PORCH_V  = VGA_BACK_PORCH_V,
  parameter int unsigned VIDEO_DELAY   = VGA_VIDEO_DELAY
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_HSync,
  input  logic       i_VSync,
  input  logic [3:0] i_Red_Video,
  input  logic [3:0] i_Grn_Video,
  input  logic [3:0] i_Blu_Video,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic [3:0] o_Red_Video,
  output logic [3:0] o_Grn_Video,
  output logic [3:0] o_Blu_Video,
  output logic       o_Locked,
  output logic       o_Resync
);

  localparam int unsigned COL_W    = ctr_width(TOTAL_COLS);
  localparam int unsigned ROW_W    = ctr_width(TOTAL_ROWS);
  localparam int unsigned HS_FIRST = ACTIVE_COLS + FRONT_PORCH_H;
  localparam int unsigned HS_LAST  = TOTAL_COLS - BACK_PORCH_H - 1;
  localparam int unsigned VS_FIRST = ACTIVE_ROWS + FRONT_PORCH_V;
  localparam int unsigned VS_LAST  = TOTAL_ROWS - BACK_PORCH_V - 1;

  logic [COL_W-1:0] w_Col;
  logic [ROW_W-1:0] w_Row;
  logic             w_Frame_Start;
  logic             w_Resync;
  lock_state_t      r_Lock_State;
  lock_state_t      w_Lock_Next;
  sync_tag_t        w_Tag;
  sync_tag_t        w_Tag_Aligned;
  logic [11:0]      r_Video_In;

  // Horizontal activity is implied by the column count; the input is only
  // accepted so the port list matches the core.
  logic             w_unused_hsync;
  assign w_unused_hsync = i_HSync;

  vga_pixel_counter #(
    .TOTAL_COLS(TOTAL_COLS),
    .TOTAL_ROWS(TOTAL_ROWS)
  ) u_pixel_counter (
    .i_Clk        (i_Clk),
    .i_Rst_L      (i_Rst_L),
    .i_VSync      (i_VSync),
    .o_Col        (w_Col),
    .o_Row        (w_Row),
    .o_Frame_Start(w_Frame_Start),
    .o_Resync     (w_Resync)
  );

  // Lock state register.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Lock_State <= LOCK_SEARCH;
    end else begin
      r_Lock_State <= w_Lock_Next;
    end
  end

  // Lock next-state plus per-sample sync/blanking decisions from the counters.
  always_comb begin
    w_Lock_Next = r_Lock_State;
    w_Tag       = '0;
    if ((r_Lock_State == LOCK_SEARCH) && w_Frame_Start) begin
      w_Lock_Next = LOCK_HELD;
    end
    w_Tag.locked = (r_Lock_State == LOCK_HELD) || w_Frame_Start;
    w_Tag.resync = w_Resync && (r_Lock_State == LOCK_HELD);
    w_Tag.hs_low = (w_Col >= COL_W'(HS_FIRST)) && (w_Col <= COL_W'(HS_LAST));
    w_Tag.vs_low = (w_Row >= ROW_W'(VS_FIRST)) && (w_Row <= ROW_W'(VS_LAST));
    w_Tag.active = (w_Col < COL_W'(ACTIVE_COLS)) && (w_Row < ROW_W'(ACTIVE_ROWS));
  end

  // Video for a sample arrives VIDEO_DELAY cycles after its sync, one cycle
  // ahead of the counter result, so the sync-side decisions are delayed by
  // VIDEO_DELAY and the video by one register to meet at the output stage.
  generate
    if (VIDEO_DELAY == 0) begin : g_no_delay
      assign w_Tag_Aligned = w_Tag;
    end else begin : g_delay
      sync_tag_t r_Tag_Dly [VIDEO_DELAY];

      // Shift the sync-side decisions down the alignment line.
      always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
          for (int unsigned i = 0; i < VIDEO_DELAY; i++) begin
            r_Tag_Dly[i] <= '0;
          end
        end else begin
          r_Tag_Dly[0] <= w_Tag;
          for (int unsigned i = 1; i < VIDEO_DELAY; i++) begin
            r_Tag_Dly[i] <= r_Tag_Dly[i-1];
          end
        end
      end

      assign w_Tag_Aligned = r_Tag_Dly[VIDEO_DELAY-1];
    end
  endgenerate

  // Capture incoming video one cycle so it lines up with the aligned tag.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Video_In <= '0;
    end else begin
      r_Video_In <= {i_Red_Video, i_Grn_Video, i_Blu_Video};
    end
  end

  // Output register: sync pulses, blanking, lock and resync, all suppressed
  // until lock.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_HSync                                  <= 1'b1;
      o_VSync                                  <= 1'b1;
      {o_Red_Video, o_Grn_Video, o_Blu_Video}  <= '0;
      o_Locked                                 <= 1'b0;
      o_Resync                                 <= 1'b0;
    end else begin
      o_HSync  <= ~(w_Tag_Aligned.locked & w_Tag_Aligned.hs_low);
      o_VSync  <= ~(w_Tag_Aligned.locked & w_Tag_Aligned.vs_low);
      o_Locked <= w_Tag_Aligned.locked;
      o_Resync <= w_Tag_Aligned.resync;
      if (w_Tag_Aligned.locked && w_Tag_Aligned.active) begin
        {o_Red_Video, o_Grn_Video, o_Blu_Video} <= r_Video_In;
      end else begin
        {o_Red_Video, o_Grn_Video, o_Blu_Video} <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_porch.sv
// Self-checking bench for vga_sync_porch on a 10x6 raster (6x4 active).
module tb_vga_sync_porch;

  localparam int TC  = 10;
  localparam int TR  = 6;
  localparam int AC  = 6;
  localparam int AR  = 4;
  localparam int FPH = 1;
  localparam int BPH = 1;
  localparam int FPV = 0;
  localparam int BPV = 1;
  localparam int VD  = 2;
  localparam int LAT = 2 + VD;
  localparam int N   = 2048;

  logic       i_Clk = 1'b0;
  logic       i_Rst_L;
  logic       i_HSync;
  logic       i_VSync;
  logic [3:0] i_Red_Video;
  logic [3:0] i_Grn_Video;
  logic [3:0] i_Blu_Video;
  logic       o_HSync;
  logic       o_VSync;
  logic [3:0] o_Red_Video;
  logic [3:0] o_Grn_Video;
  logic [3:0] o_Blu_Video;
  logic       o_Locked;
  logic       o_Resync;

  vga_sync_porch #(
    .TOTAL_COLS   (TC),
    .TOTAL_ROWS   (TR),
    .ACTIVE_COLS  (AC),
    .ACTIVE_ROWS  (AR),
    .FRONT_PORCH_H(FPH),
    .BACK_PORCH_H (BPH),
    .FRONT_PORCH_V(FPV),
    .BACK_PORCH_V (BPV),
    .VIDEO_DELAY  (VD)
  ) dut (
    .i_Clk      (i_Clk),
    .i_Rst_L    (i_Rst_L),
    .i_HSync    (i_HSync),
    .i_VSync    (i_VSync),
    .i_Red_Video(i_Red_Video),
    .i_Grn_Video(i_Grn_Video),
    .i_Blu_Video(i_Blu_Video),
    .o_HSync    (o_HSync),
    .o_VSync    (o_VSync),
    .o_Red_Video(o_Red_Video),
    .o_Grn_Video(o_Grn_Video),
    .o_Blu_Video(o_Blu_Video),
    .o_Locked   (o_Locked),
    .o_Resync   (o_Resync)
  );

  always #5 i_Clk = ~i_Clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int rs_cnt = 0;

  // Reference model state: raster position of the last sample, lock flag.
  int m_col, m_row;
  bit m_locked, m_prev_vs;
  int col_d1, col_d2;

  // Expected per-sample results, indexed by sample number since reset release.
  bit          e_hs_low [N];
  bit          e_vs_low [N];
  bit          e_act    [N];
  bit          e_lock   [N];
  bit          e_rs     [N];
  logic [11:0] vid_hist [N];
  bit          obs_lit  [N];

  task automatic model_reset();
    cyc = 0; m_col = 0; m_row = 0; m_locked = 0; m_prev_vs = 0;
  endtask

  task automatic model_sample(input logic vs, input logic [11:0] vid);
    bit fs;
    int nc, nr;
    fs = vs && !m_prev_vs;
    m_prev_vs = vs;
    nc = (m_col + 1) % TC;
    nr = (m_col == TC - 1) ? (m_row + 1) % TR : m_row;
    e_rs[cyc] = fs && m_locked && !(nc == 0 && nr == 0);
    if (fs) begin
      nc = 0; nr = 0; m_locked = 1;
    end
    m_col = nc; m_row = nr;
    e_lock[cyc]   = m_locked;
    e_hs_low[cyc] = m_locked && nc >= AC + FPH && nc <= TC - BPH - 1;
    e_vs_low[cyc] = m_locked && nr >= AR + FPV && nr <= TR - BPV - 1;
    e_act[cyc]    = m_locked && nc < AC && nr < AR;
    vid_hist[cyc] = vid;
  endtask

  task automatic compare(input int m, input logic ehs, input logic evs,
                         input logic [11:0] evid, input logic elk, input logic ers);
    logic [11:0] ovid;
    ovid = {o_Red_Video, o_Grn_Video, o_Blu_Video};
    n_vec++;
    assert (o_HSync === ehs) else begin
      n_err++; $error("FAIL hsync cyc=%0d got=%b exp=%b", m, o_HSync, ehs);
    end
    assert (o_VSync === evs) else begin
      n_err++; $error("FAIL vsync cyc=%0d got=%b exp=%b", m, o_VSync, evs);
    end
    assert (ovid === evid) else begin
      n_err++; $error("FAIL video cyc=%0d got=%h exp=%h", m, ovid, evid);
    end
    assert (o_Locked === elk) else begin
      n_err++; $error("FAIL locked cyc=%0d got=%b exp=%b", m, o_Locked, elk);
    end
    assert (o_Resync === ers) else begin
      n_err++; $error("FAIL resync cyc=%0d got=%b exp=%b", m, o_Resync, ers);
    end
  endtask

  task automatic check_cycle(input int m);
    int s;
    if (m < LAT) begin
      compare(m, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0);
    end else begin
      s = m - LAT;
      compare(m, !e_hs_low[s], !e_vs_low[s], e_act[s] ? vid_hist[s + VD] : 12'h000,
              e_lock[s], e_rs[s]);
    end
    obs_lit[m] = ({o_Red_Video, o_Grn_Video, o_Blu_Video} == 12'hFFF);
    rs_cnt += int'(o_Resync);
  endtask

  // Drive one input sample, let one clock edge pass, then check outputs.
  task automatic step(input logic vs, input logic hs, input logic [11:0] vid);
    i_VSync = vs;
    i_HSync = hs;
    {i_Red_Video, i_Grn_Video, i_Blu_Video} = vid;
    if (i_Rst_L) model_sample(vs, vid);
    @(posedge i_Clk); #1;
    if (i_Rst_L) begin
      cyc++;
      check_cycle(cyc);
    end else begin
      compare(-1, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0);
    end
  endtask

  // One frame of well-formed input syncs (possibly truncated to len samples).
  // mode 0: random video, 1: constant F, 2: video = column of sample VD earlier.
  task automatic run_frame(input int len, input int mode, input int rst_at, input int rel_at);
    int c, r;
    logic [11:0] v;
    logic [3:0] cv;
    for (int i = 0; i < len; i++) begin
      c = i % TC;
      r = i / TC;
      cv = 4'(col_d2);
      case (mode)
        1:       v = 12'hFFF;
        2:       v = {cv, cv, cv};
        default: v = 12'($urandom);
      endcase
      col_d2 = col_d1;
      col_d1 = c;
      if (i == rst_at) begin
        i_Rst_L = 1'b0;
        #1;
        compare(-2, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0);
      end
      if (i == rel_at) begin
        i_Rst_L = 1'b1;
        model_reset();
      end
      step(r < AR, c < AC, v);
    end
  endtask

  initial begin
    int s0, lit;
    i_Rst_L = 1'b0;
    i_HSync = 1'b0;
    i_VSync = 1'b0;
    {i_Red_Video, i_Grn_Video, i_Blu_Video} = '0;
    col_d1 = 0;
    col_d2 = 0;
    model_reset();

    // Reset held with random inputs, then idle without a frame start.
    for (int i = 0; i < 5; i++) step(1'($urandom), 1'($urandom), 12'($urandom));
    i_Rst_L = 1'b1;
    model_reset();
    for (int i = 0; i < 100; i++) step(1'b0, 1'($urandom), 12'($urandom));

    // First frames: lock, porch placement.
    run_frame(TC * TR, 0, -1, -1);
    run_frame(TC * TR, 0, -1, -1);

    // Blanking with constant full-scale video.
    s0 = cyc;
    run_frame(TC * TR, 1, -1, -1);
    run_frame(TC * TR, 1, -1, -1);
    lit = 0;
    for (int m = s0 + LAT; m < s0 + LAT + TC * TR; m++) lit += int'(obs_lit[m]);
    n_vec++;
    assert (lit === AC * AR) else begin
      n_err++; $error("FAIL lit_count got=%0d exp=%0d", lit, AC * AR);
    end

    // Alignment: video carries the column of its own sync sample.
    run_frame(TC * TR, 2, -1, -1);
    run_frame(TC * TR, 2, -1, -1);

    // Resync: one frame short by three samples.
    rs_cnt = 0;
    run_frame(TC * TR - 3, 0, -1, -1);
    run_frame(TC * TR, 0, -1, -1);
    run_frame(TC * TR, 0, -1, -1);
    run_frame(TC * TR, 0, -1, -1);
    n_vec++;
    assert (rs_cnt === 1) else begin
      n_err++; $error("FAIL resync_count got=%0d exp=1", rs_cnt);
    end

    // Mid-frame reset at row 2 col 3, released in vertical blanking.
    run_frame(TC * TR, 0, 2 * TC + 3, 4 * TC + 1);
    run_frame(TC * TR, 0, -1, -1);
    run_frame(TC * TR, 2, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
